// File: rtl/rbm_axil_regbank.sv
// rbm_axil_regbank: AXI4-Lite register bank for the RBM accelerator/trainer.
//   Map (byte offsets, upper address bits above ADDR_W ignored):
//     0x00 CONTROL     bit0 start (write-1 pulse, reads 0), bit1 soft_rst, [7:2] mode
//     0x04 STATUS      RO: bit0 stat_busy, bit1 pending enabled interrupt
//     0x08 INT_EN      RW, N_IRQ bits
//     0x0C INT_STATUS  rising-edge captured, write-1-to-clear
//     0x10 VERSION     RO
//     0x20+4k          CFG[k], k < N_CFG
//     0x20+4*N_CFG+4j  STAT[j], j < N_STAT (RO)
//   Ports:
//     ACLK/ARESETn          clock, asynchronous active-low reset
//     S_AW*/S_W*/S_B*       AXI4-Lite write channels (one outstanding write)
//     S_AR*/S_R*            AXI4-Lite read channels (one outstanding read)
//     ctrl_start            one-cycle pulse on CONTROL[0] write-1
//     ctrl_soft_rst/mode    CONTROL[1] / CONTROL[7:2] levels
//     cfg_q                 config word k at [32k+31:32k]
//     stat_in/stat_busy     status inputs from the core
//     irq_src/irq           interrupt sources / registered level interrupt
module rbm_axil_regbank #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned N_CFG   = 16,
  parameter int unsigned N_STAT  = 4,
  parameter int unsigned N_IRQ   = 8,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [31:0]           S_AWADDR,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [31:0]           S_WDATA,
  input  logic [3:0]            S_WSTRB,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic [1:0]            S_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [31:0]           S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [31:0]           S_RDATA,
  output logic [1:0]            S_RRESP,
  output logic                  S_RVALID,
  input  logic                  S_RREADY,
  output logic                  ctrl_start,
  output logic                  ctrl_soft_rst,
  output logic [5:0]            ctrl_mode,
  output logic [32*N_CFG-1:0]   cfg_q,
  input  logic [32*N_STAT-1:0]  stat_in,
  input  logic                  stat_busy,
  input  logic [N_IRQ-1:0]      irq_src,
  output logic                  irq
);

  localparam int unsigned CFG_BASE  = 32'h20;
  localparam int unsigned STAT_BASE = CFG_BASE + 4 * N_CFG;
  localparam int unsigned STAT_END  = STAT_BASE + 4 * N_STAT;

  logic              alive;        // keeps READYs low until the first edge after reset
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [7:1]        ctrl_bits;
  logic [N_IRQ-1:0]  int_en;
  logic [N_IRQ-1:0]  int_status;
  logic [N_IRQ-1:0]  irq_prev;

  logic              commit;
  logic [31:0]       wa;
  logic [31:0]       wmask;
  logic              wr_err;
  logic              sel_ctrl;
  logic              sel_en;
  logic              sel_ists;
  logic              sel_cfg;
  int unsigned       cfg_idx;
  logic [N_IRQ-1:0]  w1c;
  logic [N_IRQ-1:0]  rise;
  logic              irq_hit;

  logic [31:0]       ra;
  logic [31:0]       rd_word;
  logic              rd_err;
  int unsigned       rd_idx;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{S_AWADDR[31:ADDR_W], S_ARADDR[31:ADDR_W]};

  assign S_AWREADY     = alive & ~aw_held & ~S_BVALID;
  assign S_WREADY      = alive & ~w_held & ~S_BVALID;
  assign S_ARREADY     = alive & ~S_RVALID;
  assign commit        = aw_held & w_held;
  assign ctrl_soft_rst = ctrl_bits[1];
  assign ctrl_mode     = ctrl_bits[7:2];
  assign irq_hit       = |(int_status & int_en);
  assign rise          = irq_src & ~irq_prev;

  // Write address decode on the held address; select lines are only raised
  // for mapped, aligned targets so the commit logic needs no extra gating.
  always_comb begin
    wa       = 32'(aw_addr);
    wr_err   = 1'b1;
    sel_ctrl = 1'b0;
    sel_en   = 1'b0;
    sel_ists = 1'b0;
    sel_cfg  = 1'b0;
    cfg_idx  = 0;
    for (int unsigned b = 0; b < 4; b++) wmask[8*b +: 8] = {8{w_strb[b]}};
    if (wa[1:0] == 2'b00) begin
      if (wa == 32'h00) begin
        sel_ctrl = 1'b1;
        wr_err   = 1'b0;
      end else if (wa == 32'h04 || wa == 32'h10) begin
        wr_err = 1'b0;
      end else if (wa == 32'h08) begin
        sel_en = 1'b1;
        wr_err = 1'b0;
      end else if (wa == 32'h0C) begin
        sel_ists = 1'b1;
        wr_err   = 1'b0;
      end else if (wa >= CFG_BASE && wa < STAT_BASE) begin
        sel_cfg = 1'b1;
        cfg_idx = (wa - CFG_BASE) >> 2;
        wr_err  = 1'b0;
      end else if (wa >= STAT_BASE && wa < STAT_END) begin
        wr_err = 1'b0;
      end
    end
    w1c = (commit && sel_ists) ? (w_data[N_IRQ-1:0] & wmask[N_IRQ-1:0]) : '0;
  end

  always_comb begin
    ra      = 32'(S_ARADDR[ADDR_W-1:0]);
    rd_word = '0;
    rd_err  = 1'b1;
    rd_idx  = 0;
    if (ra[1:0] == 2'b00) begin
      if (ra == 32'h00) begin
        rd_word = {24'h0, ctrl_bits, 1'b0};
        rd_err  = 1'b0;
      end else if (ra == 32'h04) begin
        rd_word = {30'h0, irq_hit, stat_busy};
        rd_err  = 1'b0;
      end else if (ra == 32'h08) begin
        rd_word = 32'(int_en);
        rd_err  = 1'b0;
      end else if (ra == 32'h0C) begin
        rd_word = 32'(int_status);
        rd_err  = 1'b0;
      end else if (ra == 32'h10) begin
        rd_word = VERSION;
        rd_err  = 1'b0;
      end else if (ra >= CFG_BASE && ra < STAT_BASE) begin
        rd_idx  = (ra - CFG_BASE) >> 2;
        rd_word = cfg_q[32*rd_idx +: 32];
        rd_err  = 1'b0;
      end else if (ra >= STAT_BASE && ra < STAT_END) begin
        rd_idx  = (ra - STAT_BASE) >> 2;
        rd_word = stat_in[32*rd_idx +: 32];
        rd_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      alive      <= 1'b0;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr    <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      S_BVALID   <= 1'b0;
      S_BRESP    <= 2'b00;
      S_RVALID   <= 1'b0;
      S_RRESP    <= 2'b00;
      S_RDATA    <= '0;
      ctrl_bits  <= '0;
      ctrl_start <= 1'b0;
      int_en     <= '0;
      int_status <= '0;
      irq_prev   <= '0;
      irq        <= 1'b0;
      cfg_q      <= '0;
    end else begin
      alive      <= 1'b1;
      ctrl_start <= 1'b0;
      irq_prev   <= irq_src;
      irq        <= irq_hit;
      // A new edge wins over a simultaneous write-1-to-clear of the same bit.
      int_status <= (int_status & ~w1c) | rise;

      if (S_AWVALID && S_AWREADY) begin
        aw_held <= 1'b1;
        aw_addr <= S_AWADDR[ADDR_W-1:0];
      end
      if (S_WVALID && S_WREADY) begin
        w_held <= 1'b1;
        w_data <= S_WDATA;
        w_strb <= S_WSTRB;
      end
      if (S_BVALID && S_BREADY) S_BVALID <= 1'b0;

      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        S_BVALID <= 1'b1;
        S_BRESP  <= wr_err ? 2'b10 : 2'b00;
        if (sel_ctrl && w_strb[0]) begin
          ctrl_bits  <= w_data[7:1];
          ctrl_start <= w_data[0];
        end
        if (sel_en)
          int_en <= (int_en & ~wmask[N_IRQ-1:0]) | (w_data[N_IRQ-1:0] & wmask[N_IRQ-1:0]);
        if (sel_cfg)
          cfg_q[32*cfg_idx +: 32] <= (cfg_q[32*cfg_idx +: 32] & ~wmask) | (w_data & wmask);
      end

      if (S_ARVALID && S_ARREADY) begin
        S_RVALID <= 1'b1;
        S_RDATA  <= rd_word;
        S_RRESP  <= rd_err ? 2'b10 : 2'b00;
      end else if (S_RVALID && S_RREADY) begin
        S_RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rbm_axil_regbank.sv
module tb_rbm_axil_regbank;
  localparam int unsigned N_CFG  = 16;
  localparam int unsigned N_STAT = 4;
  localparam int unsigned N_IRQ  = 8;
  localparam logic [31:0] VER    = 32'h0002_0000;

  logic                 ACLK = 1'b0;
  logic                 ARESETn = 1'b0;
  logic [31:0]          S_AWADDR = '0;
  logic                 S_AWVALID = 1'b0;
  logic                 S_AWREADY;
  logic [31:0]          S_WDATA = '0;
  logic [3:0]           S_WSTRB = '0;
  logic                 S_WVALID = 1'b0;
  logic                 S_WREADY;
  logic [1:0]           S_BRESP;
  logic                 S_BVALID;
  logic                 S_BREADY = 1'b0;
  logic [31:0]          S_ARADDR = '0;
  logic                 S_ARVALID = 1'b0;
  logic                 S_ARREADY;
  logic [31:0]          S_RDATA;
  logic [1:0]           S_RRESP;
  logic                 S_RVALID;
  logic                 S_RREADY = 1'b0;
  logic                 ctrl_start;
  logic                 ctrl_soft_rst;
  logic [5:0]           ctrl_mode;
  logic [32*N_CFG-1:0]  cfg_q;
  logic [32*N_STAT-1:0] stat_in = '0;
  logic                 stat_busy = 1'b0;
  logic [N_IRQ-1:0]     irq_src = '0;
  logic                 irq;

  rbm_axil_regbank #(
    .ADDR_W (8),
    .N_CFG  (N_CFG),
    .N_STAT (N_STAT),
    .N_IRQ  (N_IRQ),
    .VERSION(VER)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .ctrl_start(ctrl_start), .ctrl_soft_rst(ctrl_soft_rst), .ctrl_mode(ctrl_mode),
    .cfg_q(cfg_q), .stat_in(stat_in), .stat_busy(stat_busy),
    .irq_src(irq_src), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;   // cycles on which ctrl_start was seen high
  int starts_exp = 0;

  always @(posedge ACLK) if (ctrl_start === 1'b1) start_cnt++;

  // Reference model state: the register map as plain variables.
  logic [31:0] cfg_m [N_CFG];
  logic [31:0] stat_m [N_STAT];
  logic [7:0]  ctrl_m;
  logic [7:0]  en_m;
  logic [7:0]  ists_m;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset;
    for (int k = 0; k < N_CFG; k++) cfg_m[k] = '0;
    ctrl_m = '0;
    en_m   = '0;
    ists_m = '0;
  endtask

  task automatic drive_stat;
    for (int j = 0; j < N_STAT; j++) stat_in[32*j +: 32] = stat_m[j];
  endtask

  task automatic m_write(input logic [31:0] a_full, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] resp);
    int unsigned a;
    int unsigned k;
    a = 32'(a_full[7:0]);
    resp = 2'b00;
    if (a % 4 != 0) resp = 2'b10;
    else if (a == 0) begin
      if (s[0]) begin
        ctrl_m = d[7:0] & 8'hFE;
        if (d[0]) starts_exp++;
      end
    end else if (a == 4 || a == 16) begin
      resp = 2'b00;
    end else if (a == 8) begin
      if (s[0]) en_m = d[7:0];
    end else if (a == 12) begin
      if (s[0]) ists_m = ists_m & ~d[7:0];
    end else if (a >= 32 && a < 32 + 4*N_CFG) begin
      k = (a - 32) / 4;
      for (int b = 0; b < 4; b++) if (s[b]) cfg_m[k][8*b +: 8] = d[8*b +: 8];
    end else if (a >= 32 + 4*N_CFG && a < 32 + 4*N_CFG + 4*N_STAT) begin
      resp = 2'b00;
    end else resp = 2'b10;
  endtask

  task automatic m_read(input logic [31:0] a_full, output logic [31:0] d, output logic [1:0] resp);
    int unsigned a;
    a = 32'(a_full[7:0]);
    d = '0;
    resp = 2'b00;
    if (a % 4 != 0) resp = 2'b10;
    else if (a == 0) d = {24'h0, ctrl_m};
    else if (a == 4) d = {30'h0, |(ists_m & en_m), stat_busy};
    else if (a == 8) d = {24'h0, en_m};
    else if (a == 12) d = {24'h0, ists_m};
    else if (a == 16) d = VER;
    else if (a >= 32 && a < 32 + 4*N_CFG) d = cfg_m[(a - 32) / 4];
    else if (a >= 32 + 4*N_CFG && a < 32 + 4*N_CFG + 4*N_STAT) d = stat_m[(a - 32 - 4*N_CFG) / 4];
    else resp = 2'b10;
  endtask

  task automatic do_aw(input logic [31:0] a);
    int n = 0;
    S_AWADDR = a;
    S_AWVALID = 1'b1;
    while (S_AWREADY !== 1'b1 && n < 50) begin tick; n++; end
    chk("awready", 32'(S_AWREADY), 1);
    tick;
    S_AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    S_WDATA = d;
    S_WSTRB = s;
    S_WVALID = 1'b1;
    while (S_WREADY !== 1'b1 && n < 50) begin tick; n++; end
    chk("wready", 32'(S_WREADY), 1);
    tick;
    S_WVALID = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    while (S_BVALID !== 1'b1 && n < 50) begin tick; n++; end
    chk("bvalid", 32'(S_BVALID), 1);
    resp = S_BRESP;
    S_BREADY = 1'b1;
    tick;
    S_BREADY = 1'b0;
    chk("bvalid_drop", 32'(S_BVALID), 0);
  endtask

  // order: 0 = AW and W together, 1 = AW first, 2 = W first; gap in cycles.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int gap, output logic [1:0] resp);
    int n = 0;
    if (order == 0) begin
      S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
      S_AWVALID = 1'b1; S_WVALID = 1'b1;
      while ((S_AWREADY !== 1'b1 || S_WREADY !== 1'b1) && n < 50) begin tick; n++; end
      chk("aw_w_ready", {30'h0, S_AWREADY, S_WREADY}, 32'h3);
      tick;
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
    end else if (order == 1) begin
      do_aw(a);
      repeat (gap) tick;
      do_w(d, s);
    end else begin
      do_w(d, s);
      repeat (gap) tick;
      do_aw(a);
    end
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    S_ARADDR = a;
    S_ARVALID = 1'b1;
    while (S_ARREADY !== 1'b1 && n < 50) begin tick; n++; end
    chk("arready", 32'(S_ARREADY), 1);
    tick;
    S_ARVALID = 1'b0;
    n = 0;
    while (S_RVALID !== 1'b1 && n < 50) begin tick; n++; end
    chk("rvalid", 32'(S_RVALID), 1);
    d = S_RDATA;
    resp = S_RRESP;
    S_RREADY = 1'b1;
    tick;
    S_RREADY = 1'b0;
  endtask

  task automatic chk_outputs;
    for (int k = 0; k < N_CFG; k++) chk($sformatf("cfg_q[%0d]", k), cfg_q[32*k +: 32], cfg_m[k]);
    chk("soft_rst", 32'(ctrl_soft_rst), 32'(ctrl_m[1]));
    chk("mode", 32'(ctrl_mode), 32'(ctrl_m[7:2]));
    chk("start_count", start_cnt, starts_exp);
    chk("irq", 32'(irq), 32'(|(ists_m & en_m)));
  endtask

  task automatic write_chk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order, input int gap);
    logic [1:0] er, ar;
    m_write(a, d, s, er);
    axi_write(a, d, s, order, gap, ar);
    chk($sformatf("bresp@%h", a), 32'(ar), 32'(er));
    chk_outputs();
  endtask

  task automatic read_chk(input logic [31:0] a);
    logic [31:0] ed, ad;
    logic [1:0]  er, ar;
    m_read(a, ed, er);
    axi_read(a, ad, ar);
    chk($sformatf("rdata@%h", a), ad, ed);
    chk($sformatf("rresp@%h", a), 32'(ar), 32'(er));
  endtask

  task automatic irq_pulse(input logic [7:0] r);
    irq_src = r;
    tick;
    irq_src = '0;
    tick;
    ists_m = ists_m | r;
    chk("irq_after_pulse", 32'(irq), 32'(|(ists_m & en_m)));
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0: a = 32'(4 * $urandom_range(0, 4));
      1, 2: a = 32'(32 + 4 * $urandom_range(0, N_CFG - 1));
      3: a = 32'(32 + 4 * N_CFG + 4 * $urandom_range(0, N_STAT - 1));
      4: a = 32'(4 * $urandom_range(28, 63));
      5: a = 32'(4 * $urandom_range(0, 27) + $urandom_range(1, 3));
      6: a = ($urandom_range(0, 1) == 0) ? 32'h8 : 32'hC;
      default: a = 32'($urandom_range(0, 255));
    endcase
    a[31:8] = 24'($urandom);
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d0;
    logic [31:0] rd_exp;
    logic [1:0]  rr_exp;
    logic [1:0]  br_exp;
    int          n;

    m_reset();
    for (int j = 0; j < N_STAT; j++) stat_m[j] = $urandom;
    drive_stat();

    // Reset state
    repeat (3) tick;
    chk("rst_awready", 32'(S_AWREADY), 0);
    chk("rst_arready", 32'(S_ARREADY), 0);
    chk("rst_bvalid", 32'(S_BVALID), 0);
    chk("rst_rvalid", 32'(S_RVALID), 0);
    chk("rst_irq", 32'(irq), 0);
    ARESETn = 1'b1;
    #1;
    chk("pre_edge_wready", 32'(S_WREADY), 0);
    tick;
    chk("post_rst_ready", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h7);
    chk_outputs();

    // VERSION and CONTROL after reset
    read_chk(32'h10);
    axi_read(32'h10, d0, r);
    chk("version_literal", d0, 32'h0002_0000);
    read_chk(32'h00);

    // AW several cycles ahead of W, partial strobes
    write_chk(32'h20, 32'hAABBCCDD, 4'b0101, 1, 3);
    chk("cfg0_literal", cfg_q[31:0], 32'h00BB00DD);
    write_chk(32'h24, 32'h11223344, 4'b1010, 2, 2);

    // CONTROL start pulse and stored bits
    write_chk(32'h00, 32'h0000_0007, 4'hF, 0, 0);
    chk("soft_rst_literal", 32'(ctrl_soft_rst), 1);
    chk("mode_literal", 32'(ctrl_mode), 32'h01);
    read_chk(32'h00);
    axi_read(32'h00, d0, r);
    chk("control_rb_literal", d0, 32'h6);

    // Interrupt capture, W1C, and W1C colliding with a new edge
    write_chk(32'h08, 32'h3, 4'hF, 0, 0);
    irq_pulse(8'h02);
    chk("irq_literal", 32'(irq), 1);
    read_chk(32'h0C);
    read_chk(32'h04);
    write_chk(32'h0C, 32'h2, 4'hF, 0, 0);
    tick;
    chk("irq_cleared", 32'(irq), 0);
    S_AWADDR = 32'h0C; S_WDATA = 32'h2; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    chk("coll_ready", {30'h0, S_AWREADY, S_WREADY}, 32'h3);
    tick;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    irq_src = 8'h02;   // edge lands on the commit cycle
    tick;
    irq_src = '0;
    wait_b(r);
    chk("coll_bresp", 32'(r), 0);
    ists_m = 8'h02;
    read_chk(32'h0C);
    tick;
    chk("coll_irq", 32'(irq), 1);

    // Unmapped access
    write_chk(32'h1FC, 32'hFFFF_FFFF, 4'hF, 0, 0);
    read_chk(32'h1FC);
    axi_read(32'h1FC, d0, r);
    chk("unmapped_rresp_literal", 32'(r), 32'h2);
    chk("unmapped_rdata_literal", d0, 0);
    write_chk(32'h22, 32'h5555_5555, 4'hF, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 5))
        0, 1: write_chk(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                        $urandom_range(0, 2), $urandom_range(0, 3));
        2, 3: begin
          if ($urandom_range(0, 3) == 0) begin
            for (int j = 0; j < N_STAT; j++) stat_m[j] = $urandom;
            drive_stat();
            stat_busy = 1'($urandom_range(0, 1));
          end
          read_chk(rand_addr());
        end
        4: irq_pulse(8'($urandom));
        default: write_chk(32'h08, $urandom, 4'($urandom_range(0, 15)), 0, 0);
      endcase
    end

    // Back-pressure on both response channels, then reset mid-transaction
    m_read(32'h24, rd_exp, rr_exp);
    m_write(32'h24, 32'hDEAD_BEEF, 4'hF, br_exp);
    S_AWADDR = 32'h24; S_WDATA = 32'hDEAD_BEEF; S_WSTRB = 4'hF; S_ARADDR = 32'h24;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_ARVALID = 1'b1;
    chk("stall_ready", {29'h0, S_AWREADY, S_WREADY, S_ARREADY}, 32'h7);
    tick;
    S_WVALID = 1'b0; S_ARVALID = 1'b0;
    S_AWADDR = 32'h28;  // keep offering a second write address
    n = 0;
    while ((S_BVALID !== 1'b1 || S_RVALID !== 1'b1) && n < 50) begin tick; n++; end
    for (int c = 0; c < 5; c++) begin
      chk("stall_bvalid", 32'(S_BVALID), 1);
      chk("stall_bresp", 32'(S_BRESP), 32'(br_exp));
      chk("stall_rvalid", 32'(S_RVALID), 1);
      chk("stall_rdata", S_RDATA, rd_exp);
      chk("stall_rresp", 32'(S_RRESP), 32'(rr_exp));
      chk("stall_awready", 32'(S_AWREADY), 0);
      chk("stall_arready", 32'(S_ARREADY), 0);
      tick;
    end
    chk("stall_cfg1", cfg_q[63:32], 32'hDEAD_BEEF);
    ARESETn = 1'b0;
    #1;
    S_AWVALID = 1'b0;
    chk("mid_rst_bvalid", 32'(S_BVALID), 0);
    chk("mid_rst_rvalid", 32'(S_RVALID), 0);
    chk("mid_rst_awready", 32'(S_AWREADY), 0);
    chk("mid_rst_cfg1", cfg_q[63:32], 0);
    m_reset();
    chk_outputs();
    tick;
    tick;
    ARESETn = 1'b1;
    tick;
    read_chk(32'h24);
    read_chk(32'h00);
    read_chk(32'h08);
    read_chk(32'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rbm_axil_regbank.md
Name: rbm_axil_regbank

Overview:
Parametrised AXI4-Lite register bank for the RBM accelerator and trainer. It generalises the fixed control/status register file into N_CFG read/write config words, N_STAT read-only status words and N_IRQ edge-captured interrupt sources with W1C status. It supports independent AW/W acceptance, byte strobes, a self-clearing start pulse and SLVERR on unmapped addresses. It sits between the PS AXI GP port and the RBM core/trainer.

Parameters:
ADDR_W, 8, byte-address bits decoded (S_AWADDR/S_ARADDR[ADDR_W-1:0]); upper bits ignored
N_CFG, 16, number of 32-bit RW config registers (1..32)
N_STAT, 4, number of 32-bit RO status words (1..8)
N_IRQ, 8, number of interrupt sources (1..32)
VERSION, 32'h0002_0000, value of the VERSION register

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
S_AWADDR  in  32  write address
S_AWVALID/S_AWREADY  in/out  1  write address handshake
S_WDATA  in  32  write data
S_WSTRB  in  4  byte strobes
S_WVALID/S_WREADY  in/out  1  write data handshake
S_BRESP  out  2  00 OKAY, 10 SLVERR
S_BVALID/S_BREADY  out/in  1  write response handshake
S_ARADDR  in  32  read address
S_ARVALID/S_ARREADY  in/out  1  read address handshake
S_RDATA  out  32  read data
S_RRESP  out  2  00 OKAY, 10 SLVERR
S_RVALID/S_RREADY  out/in  1  read data handshake
ctrl_start  out  1  one-cycle pulse
ctrl_soft_rst  out  1  level, CONTROL[1]
ctrl_mode  out  6  CONTROL[7:2]
cfg_q  out  32*N_CFG  config word k at [32k+31:32k]
stat_in  in  32*N_STAT  status word k
stat_busy  in  1  core busy
irq_src  in  N_IRQ  interrupt sources, rising-edge captured
irq  out  1  level interrupt

Behaviour:
- Map: 0x00 CONTROL; 0x04 STATUS (RO: bit0 stat_busy, bit1 |(INT_STATUS&INT_EN)); 0x08 INT_EN; 0x0C INT_STATUS (W1C); 0x10 VERSION (RO); 0x20+4k CFG[k], k<N_CFG; 0x20+4*N_CFG+4j STAT[j], j<N_STAT (RO). Others unmapped.
- Reset (ARESETn low, async): all READY/VALID low, BRESP/RRESP 00, RDATA 0, CONTROL 0, INT_EN 0, INT_STATUS 0, cfg_q 0, irq 0, ctrl_start 0, irq_src edge history 0. READYs rise on the first cycle after deassertion.
- Write channel: AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID. Address and data latch independently in any order or in the same cycle. Commit happens the cycle both are held; BVALID asserts the next cycle and holds until BREADY; the held flags clear at commit. One outstanding write.
- Commit: byte lane b updates iff WSTRB[b]. CONTROL: bit0 write-1 raises ctrl_start for exactly one cycle after commit and always reads 0; bits[7:1] stored. INT_STATUS: written 1s clear bits (strobe-qualified). Writes to RO registers are ignored and return OKAY. Unmapped or unaligned address (addr[1:0]!=0): no state change, BRESP=SLVERR.
- Read channel: ARREADY = !RVALID. On AR handshake, RDATA/RRESP are registered and RVALID asserts the next cycle, holding stable until RREADY. Unmapped or unaligned reads: RDATA=0, RRESP=SLVERR. Unimplemented bits read 0. One outstanding read; the read and write channels are fully independent.
- Interrupts: irq_src is sampled each cycle; a rising edge (prev 0, now 1) sets INT_STATUS[i]. A set in the same cycle as a W1C of the same bit leaves the bit set. irq = |(INT_STATUS & INT_EN), registered with one cycle latency. INT_EN bits at or above N_IRQ read 0.
- ctrl_soft_rst does not reset this block.

Test Plan:
- Reset then read 0x10 -> RDATA 32'h0002_0000, RRESP 00; read 0x00 -> 0.
- AW sent 3 cycles before W, write 0x20 data 32'hAABBCCDD with WSTRB 4'b0101 -> one BVALID, OKAY; cfg_q[31:0]=32'h00BB00DD.
- Write CONTROL 32'h0000_0007 -> ctrl_start high for exactly 1 cycle; ctrl_soft_rst=1, ctrl_mode=6'h01; readback 32'h6.
- INT_EN=0x3, irq_src[1] pulses -> INT_STATUS=0x2 and irq=1; W1C 0x2 -> irq=0. A W1C issued in the same cycle as a new irq_src[1] edge -> bit stays 1.
- Write and read 0x1FC (unmapped) -> BRESP and RRESP = 10, RDATA 0, no cfg_q change.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable, AWREADY/ARREADY stay low; assert ARESETn low mid-transaction -> all VALIDs drop immediately and registers return to 0.
